// File: rtl/route_concat.sv
// -----------------------------------------------------------------------------
// route_concat
//   Channel-concatenation stage for route layers. Two feature-map streams with
//   the same row-major pixel order are merged so that, for every pixel, all
//   channel beats of stream A are emitted, followed by all channel beats of
//   stream B.
//
// Optional feature macro: ROUTE_CONCAT_SWAP_EN
//   When defined, the Swap_Order input is present. It is latched at Start, and
//   when it is 1, B precedes A within each pixel.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   Start               one-cycle start pulse (sampled only in IDLE)
//   Next_Reg            synchronous abort/reload back to IDLE
//   Row_Num_Out_REG     feature width (= height) in pixels
//   Channel_A/B_Num_REG channel counts (multiples of 16); beats = count >> 4
//   S0_* / S1_*         input streams A / B (valid/ready)
//   M_*                 merged output stream (registered data/valid)
//   Last_Concat         high with the final output beat of the frame
//   Concat_Complete     one-cycle pulse once the frame has fully drained
// -----------------------------------------------------------------------------
module route_concat #(
  parameter int DATA_WIDTH            = 256,
  parameter int WIDTH_CHANNEL_NUM_REG = 11,
  parameter int WIDTH_FEATURE_SIZE    = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic                             Next_Reg,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_A_Num_REG,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_B_Num_REG,
`ifdef ROUTE_CONCAT_SWAP_EN
  input  logic                             Swap_Order,
`endif
  input  logic [DATA_WIDTH-1:0]            S0_Data,
  input  logic                             S0_Valid,
  output logic                             S0_Ready,
  input  logic [DATA_WIDTH-1:0]            S1_Data,
  input  logic                             S1_Valid,
  output logic                             S1_Ready,
  output logic [DATA_WIDTH-1:0]            M_Data,
  output logic                             M_Valid,
  input  logic                             M_Ready,
  output logic                             Last_Concat,
  output logic                             Concat_Complete
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL_A = 2'd1,
    SEL_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH_CHANNEL_NUM_REG-1:0] CH_ZERO = {WIDTH_CHANNEL_NUM_REG{1'b0}};
  localparam logic [WIDTH_CHANNEL_NUM_REG-1:0] CH_ONE  = {{(WIDTH_CHANNEL_NUM_REG-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_FEATURE_SIZE-1:0]    FS_ZERO = {WIDTH_FEATURE_SIZE{1'b0}};
  localparam logic [WIDTH_FEATURE_SIZE-1:0]    FS_ONE  = {{(WIDTH_FEATURE_SIZE-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]            DATA_ZERO = {DATA_WIDTH{1'b0}};

  // First non-empty source of a pixel, honouring the requested order.
  function automatic state_t first_src(input logic [WIDTH_CHANNEL_NUM_REG-1:0] ta,
                                       input logic [WIDTH_CHANNEL_NUM_REG-1:0] tb,
                                       input logic swap);
    if (swap) begin
      first_src = (tb != CH_ZERO) ? SEL_B : SEL_A;
    end else begin
      first_src = (ta != CH_ZERO) ? SEL_A : SEL_B;
    end
  endfunction

  state_t                           state_q, state_d;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] ta_q, ta_d, tb_q, tb_d;
  logic [WIDTH_FEATURE_SIZE-1:0]    n_q, n_d;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] cnt_beat_q, cnt_beat_d;
  logic [WIDTH_FEATURE_SIZE-1:0]    cnt_col_q, cnt_col_d, cnt_row_q, cnt_row_d;
  logic [DATA_WIDTH-1:0]            m_data_q, m_data_d;
  logic                             m_valid_q, m_valid_d;
  logic                             last_q, last_d;
  logic                             complete_q, complete_d;

  logic swap_s;        // order used by the running frame
  logic start_swap_s;  // order requested at Start
`ifdef ROUTE_CONCAT_SWAP_EN
  logic swap_q, swap_d;
  assign swap_s       = swap_q;
  assign start_swap_s = Swap_Order;
`else
  assign swap_s       = 1'b0;
  assign start_swap_s = 1'b0;
`endif

  logic [WIDTH_CHANNEL_NUM_REG-1:0] start_ta_s, start_tb_s;
  logic out_ld_s, a_acc_s, b_acc_s, a_end_s, b_end_s;
  logic pixel_end_s, col_last_s, row_last_s, frame_end_s;

  assign start_ta_s = Channel_A_Num_REG >> 4;
  assign start_tb_s = Channel_B_Num_REG >> 4;

  // Output register can take a new beat when empty or being drained.
  assign out_ld_s = ~m_valid_q | M_Ready;
  assign S0_Ready = (state_q == SEL_A) & out_ld_s;
  assign S1_Ready = (state_q == SEL_B) & out_ld_s;
  assign a_acc_s  = S0_Valid & S0_Ready;
  assign b_acc_s  = S1_Valid & S1_Ready;
  assign a_end_s  = a_acc_s & ((cnt_beat_q + CH_ONE) == ta_q);
  assign b_end_s  = b_acc_s & ((cnt_beat_q + CH_ONE) == tb_q);

  // A pixel ends on the last beat of whichever source comes second, or of the
  // only source when the other one is empty.
  assign pixel_end_s = (a_end_s & (swap_s | (tb_q == CH_ZERO))) |
                       (b_end_s & (~swap_s | (ta_q == CH_ZERO)));
  assign col_last_s  = (cnt_col_q + FS_ONE) == n_q;
  assign row_last_s  = (cnt_row_q + FS_ONE) == n_q;
  assign frame_end_s = pixel_end_s & col_last_s & row_last_s;

  assign M_Data          = m_data_q;
  assign M_Valid         = m_valid_q;
  assign Last_Concat     = last_q;
  assign Concat_Complete = complete_q;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d    = state_q;
    ta_d       = ta_q;
    tb_d       = tb_q;
    n_d        = n_q;
    cnt_beat_d = cnt_beat_q;
    cnt_col_d  = cnt_col_q;
    cnt_row_d  = cnt_row_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    last_d     = last_q;
    complete_d = 1'b0;
`ifdef ROUTE_CONCAT_SWAP_EN
    swap_d     = swap_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          ta_d       = start_ta_s;
          tb_d       = start_tb_s;
          n_d        = Row_Num_Out_REG;
          cnt_beat_d = CH_ZERO;
          cnt_col_d  = FS_ZERO;
          cnt_row_d  = FS_ZERO;
`ifdef ROUTE_CONCAT_SWAP_EN
          swap_d     = Swap_Order;
`endif
          // An empty frame (no channels or no pixels) goes straight to DONE.
          if (((start_ta_s == CH_ZERO) && (start_tb_s == CH_ZERO)) ||
              (Row_Num_Out_REG == FS_ZERO)) begin
            state_d = DONE;
          end else begin
            state_d = first_src(start_ta_s, start_tb_s, start_swap_s);
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEL_A: begin
        if (a_end_s) begin
          cnt_beat_d = CH_ZERO;
          state_d    = pixel_end_s ? state_q : SEL_B;
        end else if (a_acc_s) begin
          cnt_beat_d = cnt_beat_q + CH_ONE;
        end else begin
          cnt_beat_d = cnt_beat_q;
        end
      end
      SEL_B: begin
        if (b_end_s) begin
          cnt_beat_d = CH_ZERO;
          state_d    = pixel_end_s ? state_q : SEL_A;
        end else if (b_acc_s) begin
          cnt_beat_d = cnt_beat_q + CH_ONE;
        end else begin
          cnt_beat_d = cnt_beat_q;
        end
      end
      DONE: begin
        if (!m_valid_q) begin
          complete_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pixel-end path shared by both source states.
    if (pixel_end_s) begin
      if (col_last_s) begin
        cnt_col_d = FS_ZERO;
        cnt_row_d = row_last_s ? FS_ZERO : (cnt_row_q + FS_ONE);
      end else begin
        cnt_col_d = cnt_col_q + FS_ONE;
      end
      state_d = frame_end_s ? DONE : first_src(ta_q, tb_q, swap_s);
    end else begin
      cnt_col_d = cnt_col_d;
    end

    // Output register: one beat of latency, holds while stalled.
    if (out_ld_s) begin
      m_valid_d = a_acc_s | b_acc_s;
      last_d    = frame_end_s;
      if (a_acc_s) begin
        m_data_d = S0_Data;
      end else if (b_acc_s) begin
        m_data_d = S1_Data;
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      m_valid_d = m_valid_q;
    end

    // Abort/reload overrides everything; any held beat is dropped.
    if (Next_Reg) begin
      state_d    = IDLE;
      cnt_beat_d = CH_ZERO;
      cnt_col_d  = FS_ZERO;
      cnt_row_d  = FS_ZERO;
      m_data_d   = DATA_ZERO;
      m_valid_d  = 1'b0;
      last_d     = 1'b0;
      complete_d = 1'b0;
    end else begin
      complete_d = complete_d;
    end
  end

  // State, configuration, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ta_q       <= CH_ZERO;
      tb_q       <= CH_ZERO;
      n_q        <= FS_ZERO;
      cnt_beat_q <= CH_ZERO;
      cnt_col_q  <= FS_ZERO;
      cnt_row_q  <= FS_ZERO;
      m_data_q   <= DATA_ZERO;
      m_valid_q  <= 1'b0;
      last_q     <= 1'b0;
      complete_q <= 1'b0;
`ifdef ROUTE_CONCAT_SWAP_EN
      swap_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ta_q       <= ta_d;
      tb_q       <= tb_d;
      n_q        <= n_d;
      cnt_beat_q <= cnt_beat_d;
      cnt_col_q  <= cnt_col_d;
      cnt_row_q  <= cnt_row_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      last_q     <= last_d;
      complete_q <= complete_d;
`ifdef ROUTE_CONCAT_SWAP_EN
      swap_q     <= swap_d;
`endif
    end
  end

endmodule

// File: tb/tb_route_concat.sv
// -----------------------------------------------------------------------------
// tb_route_concat
//   Directed bench for route_concat. Each frame's expected beat sequence is
//   built from its configuration (A beats then B beats per pixel, or the
//   reverse when swapped), and every output transfer is compared against it.
// -----------------------------------------------------------------------------
module tb_route_concat;

  logic         clk;
  logic         rst;
  logic         Start;
  logic         Next_Reg;
  logic [11:0]  Row_Num_Out_REG;
  logic [10:0]  Channel_A_Num_REG;
  logic [10:0]  Channel_B_Num_REG;
`ifdef ROUTE_CONCAT_SWAP_EN
  logic         Swap_Order;
`endif
  logic [255:0] S0_Data;
  logic         S0_Valid;
  logic         S0_Ready;
  logic [255:0] S1_Data;
  logic         S1_Valid;
  logic         S1_Ready;
  logic [255:0] M_Data;
  logic         M_Valid;
  logic         M_Ready;
  logic         Last_Concat;
  logic         Concat_Complete;

  int errors = 0;
  int checks = 0;

  route_concat dut (
    .clk               (clk),
    .rst               (rst),
    .Start             (Start),
    .Next_Reg          (Next_Reg),
    .Row_Num_Out_REG   (Row_Num_Out_REG),
    .Channel_A_Num_REG (Channel_A_Num_REG),
    .Channel_B_Num_REG (Channel_B_Num_REG),
`ifdef ROUTE_CONCAT_SWAP_EN
    .Swap_Order        (Swap_Order),
`endif
    .S0_Data           (S0_Data),
    .S0_Valid          (S0_Valid),
    .S0_Ready          (S0_Ready),
    .S1_Data           (S1_Data),
    .S1_Valid          (S1_Valid),
    .S1_Ready          (S1_Ready),
    .M_Data            (M_Data),
    .M_Valid           (M_Valid),
    .M_Ready           (M_Ready),
    .Last_Concat       (Last_Concat),
    .Concat_Complete   (Concat_Complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] dat_a(input int i);
    dat_a = {224'd0, 16'hAAAA, i[15:0]};
  endfunction

  function automatic logic [255:0] dat_b(input int i);
    dat_b = {224'd0, 16'hBBBB, i[15:0]};
  endfunction

  // Runs one frame. abort_kind: 0 = run to completion, 1 = Next_Reg after
  // abort_after accepted input beats, 2 = rst low after abort_after beats.
  task automatic run_frame(input string tag, input int ta, input int tb, input int n,
                           input bit swap, input bit toggle_rdy,
                           input int abort_kind, input int abort_after);
    logic [255:0] exp_q[$];
    logic [255:0] exp_v;
    logic [255:0] prev_data;
    bit           prev_stall = 1'b0;
    bit           s0_seen = 1'b0;
    bit           a_acc, b_acc;
    bit           rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int           ai = 0, bi = 0, a_idx = 0, b_idx = 0;
    int           xfers = 0, accepted = 0, cyc = 0;
    int           last_xfer_cyc = -1, cpl_cyc = -1, cpl_cnt = 0;
    int           total = n * n * (ta + tb);

    for (int p = 0; p < n * n; p++) begin
      if (swap) begin
        for (int k = 0; k < tb; k++) exp_q.push_back(dat_b(bi++));
        for (int k = 0; k < ta; k++) exp_q.push_back(dat_a(ai++));
      end else begin
        for (int k = 0; k < ta; k++) exp_q.push_back(dat_a(ai++));
        for (int k = 0; k < tb; k++) exp_q.push_back(dat_b(bi++));
      end
    end

    @(negedge clk);
    Channel_A_Num_REG = 11'(ta * 16);
    Channel_B_Num_REG = 11'(tb * 16);
    Row_Num_Out_REG   = 12'(n);
`ifdef ROUTE_CONCAT_SWAP_EN
    Swap_Order        = swap;
`endif
    S0_Data  = dat_a(0);
    S1_Data  = dat_b(0);
    Start    = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    // Configuration is latched at Start; later changes must be ignored.
    Channel_A_Num_REG = 11'h7F0;
    Channel_B_Num_REG = 11'h7F0;
    Row_Num_Out_REG   = 12'd7;
`ifdef ROUTE_CONCAT_SWAP_EN
    Swap_Order        = ~swap;
`endif

    while (cyc < 4 * total + 40) begin
      M_Ready = toggle_rdy ? rdy_pat[cyc % 4] : 1'b1;
      S0_Data = dat_a(a_idx);
      S1_Data = dat_b(b_idx);
      #1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 256'(M_Valid), 256'd1);
        check({tag, "_hold_data"}, M_Data, prev_data);
      end
      if (M_Valid && !M_Ready) begin
        check({tag, "_stall_s0rdy"}, 256'(S0_Ready), 256'd0);
        check({tag, "_stall_s1rdy"}, 256'(S1_Ready), 256'd0);
      end
      if (M_Valid && M_Ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, M_Data, 256'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check({tag, "_data"}, M_Data, exp_v);
          check({tag, "_last"}, 256'(Last_Concat), 256'(exp_q.size() == 0));
        end
        xfers++;
        last_xfer_cyc = cyc;
      end
      if (Concat_Complete) begin
        cpl_cnt++;
        cpl_cyc = cyc;
      end
      if (S0_Ready) s0_seen = 1'b1;
      a_acc      = S0_Valid && S0_Ready;
      b_acc      = S1_Valid && S1_Ready;
      prev_stall = M_Valid && !M_Ready;
      prev_data  = M_Data;
      @(posedge clk);
      if (a_acc) begin a_idx++; accepted++; end
      if (b_acc) begin b_idx++; accepted++; end
      cyc++;
      @(negedge clk);
      if (abort_kind != 0 && accepted >= abort_after) break;
      if (cpl_cnt > 0 && cyc >= cpl_cyc + 3) break;
    end

    if (abort_kind == 1) begin
      Next_Reg = 1'b1;
      M_Ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Next_Reg = 1'b0;
      #1;
      check({tag, "_abort_valid"}, 256'(M_Valid), 256'd0);
      check({tag, "_abort_last"}, 256'(Last_Concat), 256'd0);
      check({tag, "_abort_s0rdy"}, 256'(S0_Ready), 256'd0);
      check({tag, "_abort_s1rdy"}, 256'(S1_Ready), 256'd0);
    end else if (abort_kind == 2) begin
      rst = 1'b0;
      #1;
      check({tag, "_rst_valid"}, 256'(M_Valid), 256'd0);
      check({tag, "_rst_data"}, M_Data, 256'd0);
      check({tag, "_rst_last"}, 256'(Last_Concat), 256'd0);
      check({tag, "_rst_cpl"}, 256'(Concat_Complete), 256'd0);
      check({tag, "_rst_s0rdy"}, 256'(S0_Ready), 256'd0);
      check({tag, "_rst_s1rdy"}, 256'(S1_Ready), 256'd0);
      @(negedge clk);
      rst = 1'b1;
    end else begin
      check({tag, "_beats"}, 256'(xfers), 256'(total));
      check({tag, "_cpl_count"}, 256'(cpl_cnt), 256'd1);
      check({tag, "_cpl_latency"}, 256'(cpl_cyc - last_xfer_cyc), 256'd2);
      if (ta == 0) check({tag, "_s0_never_ready"}, 256'(s0_seen), 256'd0);
    end
  endtask

  initial begin
    rst               = 1'b0;
    Start             = 1'b0;
    Next_Reg          = 1'b0;
    Row_Num_Out_REG   = 12'd0;
    Channel_A_Num_REG = 11'd0;
    Channel_B_Num_REG = 11'd0;
`ifdef ROUTE_CONCAT_SWAP_EN
    Swap_Order        = 1'b0;
`endif
    S0_Data  = 256'd0;
    S0_Valid = 1'b1;
    S1_Data  = 256'd0;
    S1_Valid = 1'b1;
    M_Ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_valid", 256'(M_Valid), 256'd0);
    check("reset_data", M_Data, 256'd0);
    check("reset_last", 256'(Last_Concat), 256'd0);
    check("reset_cpl", 256'(Concat_Complete), 256'd0);
    check("reset_s0rdy", 256'(S0_Ready), 256'd0);
    check("reset_s1rdy", 256'(S1_Ready), 256'd0);
    rst = 1'b1;
    @(negedge clk);

    run_frame("basic", 2, 1, 2, 1'b0, 1'b0, 0, 0);
    run_frame("stall", 2, 1, 2, 1'b0, 1'b1, 0, 0);
    run_frame("a_empty", 0, 3, 1, 1'b0, 1'b0, 0, 0);
    run_frame("abort", 1, 1, 3, 1'b0, 1'b0, 1, 5);
    run_frame("after_abort", 1, 1, 3, 1'b0, 1'b0, 0, 0);
    run_frame("rst_mid", 2, 1, 2, 1'b0, 1'b1, 2, 3);
    run_frame("after_rst", 2, 1, 2, 1'b0, 1'b0, 0, 0);
`ifdef ROUTE_CONCAT_SWAP_EN
    run_frame("swap", 1, 2, 1, 1'b1, 1'b0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
